// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, default constants and helpers for the 4x4
//               keypad scanner: FSM state encoding, key code map, column
//               drive pattern and row priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int unsigned C_SCAN_PERIOD_DEFAULT     = 1000;
    localparam int unsigned C_DEBOUNCE_CYCLES_DEFAULT = 50000;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Hex code printed on the key at (row, col).
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Index of the lowest-numbered row reading low; only called when at least one is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Active-low one-hot drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
// ============================================================================
// Module      : sync2
// Description : Multi-bit two-flop synchronizer for slow, independently
//               changing asynchronous levels (keypad rows).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int unsigned WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops; reset to the idle (released) level so no false press is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad matrix scanner. Drives one column at a time,
//               debounces press and release of the detected key, pulses
//               key_valid once per accepted press and keeps the two most
//               recent key codes as display digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD     = C_SCAN_PERIOD_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [3:0] digit0,
    output logic [3:0] digit1
);

    localparam int unsigned C_CNT_MAX = (SCAN_PERIOD > DEBOUNCE_CYCLES) ? SCAN_PERIOD
                                                                         : DEBOUNCE_CYCLES;
    localparam int unsigned C_CW      = $clog2(C_CNT_MAX);
    localparam logic [C_CW-1:0] C_SCAN_LAST = C_CW'(SCAN_PERIOD - 1);
    localparam logic [C_CW-1:0] C_DB_LAST   = C_CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]      w_rs_n;
    logic [1:0]      w_col_next;
    logic            w_row_high;
    logic [3:0]      w_code;

    state_t          r_state;
    logic [C_CW-1:0] r_cnt;
    logic [1:0]      r_col;
    logic [1:0]      r_row;
    logic [3:0]      r_cols_n;
    logic [3:0]      r_key;
    logic            r_key_valid;
    logic [3:0]      r_digit0;
    logic [3:0]      r_digit1;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (reset),
        .i_d (rows_n),
        .o_q (w_rs_n)
    );

    assign w_col_next = r_col + 2'd1;
    assign w_row_high = w_rs_n[r_row];
    assign w_code     = keymap(r_row, r_col);

    // Scan / debounce / hold / release FSM with its shared counter, column ring and digit shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_cnt       <= '0;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_cols_n    <= 4'b1110;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_digit0    <= 4'h0;
            r_digit1    <= 4'h0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_cnt == C_SCAN_LAST) begin
                        r_cnt <= '0;
                        if (w_rs_n == 4'hF) begin
                            r_col    <= w_col_next;
                            r_cols_n <= col_drive(w_col_next);
                        end else begin
                            // Column stays driven; r_col already names the pressed column.
                            r_row   <= lowest_low_row(w_rs_n);
                            r_state <= DEBOUNCE;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_row_high) begin
                        // Glitch or too-short press: give up on this column and move on.
                        r_state  <= SCAN;
                        r_cnt    <= '0;
                        r_col    <= w_col_next;
                        r_cols_n <= col_drive(w_col_next);
                    end else if (r_cnt == C_DB_LAST) begin
                        r_state     <= HELD;
                        r_cnt       <= '0;
                        r_key       <= w_code;
                        r_digit1    <= r_digit0;
                        r_digit0    <= w_code;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
                HELD: begin
                    if (w_row_high) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                    end
                end
                RELEASE: begin
                    if (!w_row_high) begin
                        // Release bounce: the high run must restart from zero.
                        r_cnt <= '0;
                    end else if (r_cnt == C_DB_LAST) begin
                        r_state  <= SCAN;
                        r_cnt    <= '0;
                        r_col    <= w_col_next;
                        r_cols_n <= col_drive(w_col_next);
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
                default: begin
                    r_state <= SCAN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cols_n    = r_cols_n;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign digit0    = r_digit0;
    assign digit1    = r_digit1;

endmodule

`default_nettype wire
